// File: rtl/display_scan_if.sv
// display_scan_if: bundles the scan controller's datapath-side and pin-side
// signals.
//   en, value, load, blank_lz : produced by the BCD datapath (master)
//   pending                   : staged value not yet on the display
//   bcd, dec_en               : to the shared bcdtoseg decoder
//   anode                     : active-low digit drives
//   digit, frame              : current digit index, end-of-frame pulse
interface display_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic                  load;
  logic                  blank_lz;
  logic                  pending;
  logic [3:0]            bcd;
  logic                  dec_en;
  logic [DIGITS-1:0]     anode;
  logic [2:0]            digit;
  logic                  frame;

  modport master (
    output en, value, load, blank_lz,
    input  pending, bcd, dec_en, anode, digit, frame
  );

  modport slave (
    input  en, value, load, blank_lz,
    output pending, bcd, dec_en, anode, digit, frame
  );
endinterface

// File: rtl/display_scan.sv
// display_scan: multiplexed seven-segment scan controller sharing one
// bcdtoseg decoder across DIGITS common-anode digits.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : display_scan_if slave port (load side and display side)
// The displayed value lives in a shadow register that only changes on a
// frame boundary, so a frame never mixes digits of two different values.
// Each digit visit is GUARD dark cycles followed by DIV lit cycles.
module display_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 500
) (
  input logic           clk,
  input logic           rst,
  display_scan_if.slave bus
);
  localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_SHOW} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [4*DIGITS-1:0] staging, shadow, shadow_n;
  logic                pending_r;
  logic [3:0]          bcd_r;
  logic                dec_en_r;
  logic [DIGITS-1:0]   anode_r;
  logic [2:0]          digit_r;
  logic                frame_r;
  logic                boundary;
  logic [4*DIGITS-1:0] sel_shift;

  // Digit i>0 is blanked when it and every more significant digit are zero.
  function automatic logic blanked(input logic [IW-1:0] i,
                                   input logic [4*DIGITS-1:0] s,
                                   input logic bl);
    logic z;
    z = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++)
      if (k >= 32'(i) && s[4*k +: 4] != 4'd0) z = 1'b0;
    return bl && (i != '0) && z;
  endfunction

  assign boundary = (state == S_OFF) ||
                    (state == S_SHOW && idx == LAST && cnt == CW'(DIV - 1));

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    shadow_n = shadow;
    if (!bus.en) begin
      state_n = S_OFF;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_GUARD;
          idx_n   = '0;
          cnt_n   = '0;
        end
        S_GUARD: begin
          if (cnt == CW'(GUARD - 1)) begin
            state_n = S_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == CW'(DIV - 1)) begin
            state_n = S_GUARD;
            cnt_n   = '0;
            idx_n   = (idx == LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_OFF;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
    // A load landing on the boundary bypasses staging straight to shadow.
    if (boundary) begin
      if (bus.load)       shadow_n = bus.value;
      else if (pending_r) shadow_n = staging;
    end
    sel_shift = shadow_n >> {idx_n, 2'b00};
  end

  // Outputs are computed from the next state so they are registered yet
  // describe the cycle being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_OFF;
      idx       <= '0;
      cnt       <= '0;
      staging   <= '0;
      shadow    <= '0;
      pending_r <= 1'b0;
      bcd_r     <= '0;
      dec_en_r  <= 1'b0;
      anode_r   <= '1;
      digit_r   <= '0;
      frame_r   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
      if (bus.load) staging <= bus.value;
      if (boundary)      pending_r <= 1'b0;
      else if (bus.load) pending_r <= 1'b1;
      digit_r  <= 3'(idx_n);
      frame_r  <= (state_n == S_SHOW) && (idx_n == LAST) && (cnt_n == CW'(DIV - 1));
      anode_r  <= '1;
      dec_en_r <= 1'b0;
      bcd_r    <= (state_n == S_OFF) ? 4'd0 : sel_shift[3:0];
      if (state_n == S_SHOW) begin
        anode_r  <= ~(DIGITS'(1) << idx_n);
        dec_en_r <= !blanked(idx_n, shadow_n, bus.blank_lz);
      end
    end
  end

  assign bus.pending = pending_r;
  assign bus.bcd     = bcd_r;
  assign bus.dec_en  = dec_en_r;
  assign bus.anode   = anode_r;
  assign bus.digit   = digit_r;
  assign bus.frame   = frame_r;
endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;
  localparam int D  = 4;
  localparam int DV = 4;
  localparam int G  = 1;
  localparam int P  = G + DV;
  localparam int F  = D * P;

  typedef struct packed {
    logic         pending;
    logic [3:0]   bcd;
    logic         dec_en;
    logic [D-1:0] anode;
    logic [2:0]   digit;
    logic         frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [4*D-1:0] value = '0;

  display_scan_if #(.DIGITS(D)) bus ();
  assign bus.en       = en;
  assign bus.load     = load;
  assign bus.value    = value;
  assign bus.blank_lz = blank_lz;

  display_scan #(.DIGITS(D), .DIV(DV), .GUARD(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model: position t within the frame timeline.
  bit             m_run = 1'b0;
  int             m_t = 0;
  logic [4*D-1:0] m_shadow = '0, m_staging = '0;
  logic           m_pending = 1'b0;
  exp_t           sbq[$];

  function automatic exp_t expect_now();
    exp_t e;
    int d, ph;
    e = '0;
    e.anode = '1;
    e.pending = m_pending;
    if (m_run) begin
      d  = m_t / P;
      ph = m_t % P;
      e.digit = 3'(d);
      e.bcd   = 4'((m_shadow >> (4 * d)) & 16'hF);
      e.frame = (m_t == F - 1);
      if (ph >= G) begin
        e.anode  = ~(D'(1) << d);
        e.dec_en = !(blank_lz && d > 0 && (m_shadow >> (4 * d)) == 0);
      end
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit bnd;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_shadow = '0; m_staging = '0; m_pending = 1'b0;
      sbq.delete();
      sbq.push_back(expect_now());
    end else begin
      bnd = !m_run || (m_t == F - 1);
      if (bnd && (m_pending || load)) begin
        m_shadow  = load ? value : m_staging;
        m_pending = 1'b0;
      end else if (load) begin
        m_pending = 1'b1;
      end
      if (load) m_staging = value;
      if (!en) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % F;
      end
      sbq.push_back(expect_now());
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  logic [D-1:0] prev_anode = '1;

  always @(negedge clk) begin
    exp_t e;
    int lows;
    if (mon_on) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("pending", 32'(bus.pending), 32'(e.pending));
        chk("bcd",     32'(bus.bcd),     32'(e.bcd));
        chk("dec_en",  32'(bus.dec_en),  32'(e.dec_en));
        chk("anode",   32'(bus.anode),   32'(e.anode));
        chk("digit",   32'(bus.digit),   32'(e.digit));
        chk("frame",   32'(bus.frame),   32'(e.frame));
      end
      lows = 0;
      for (int i = 0; i < D; i++) if (bus.anode[i] === 1'b0) lows++;
      chk("one_anode_max", 32'(lows <= 1), 32'd1);
      chk("anode_gap",
          32'((prev_anode == '1) || (bus.anode == '1) || (bus.anode == prev_anode)), 32'd1);
      prev_anode = bus.anode;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_t(input int target);
    int k;
    k = 0;
    while (!(m_run && m_t == target) && k < 200) begin
      step(1);
      k++;
    end
    chk("wait_timeline", 32'(k < 200), 32'd1);
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  function automatic logic [4*D-1:0] rand_val();
    logic [4*D-1:0] v;
    int keep;
    v = 16'($urandom);
    if ($urandom_range(1) == 0) begin
      keep = $urandom_range(D - 1);
      v = v & ((16'd1 << (4 * keep)) - 16'd1);
    end
    return v;
  endfunction

  initial begin
    #1 rst = 1'b1;
    mon_on = 1'b1;
    #20 rst = 1'b0;
    step(1);
    // reset then enable
    en = 1'b1;
    step(50);
    // load while dark, then scan 1234
    en = 1'b0;
    step(2);
    do_load(16'h1234);
    en = 1'b1;
    step(25);
    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050);
    step(45);
    do_load(16'h0000);
    step(45);
    // mid-frame load stays hidden until next frame
    wait_t(7);
    do_load(16'h1111);
    step(45);
    // load coincident with frame boundary
    wait_t(F - 1);
    do_load(16'h2345);
    step(25);
    // en drop during digit 2 SHOW, then re-enable
    wait_t(2 * P + 2);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(25);
    // async reset mid-SHOW discards a staged value
    wait_t(2);
    do_load(16'h9876);
    rst = 1'b1;
    #6 rst = 1'b0;
    step(25);
    // non-BCD digit passes through
    blank_lz = 1'b0;
    do_load(16'hA0B3);
    step(25);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(7) == 0);
      if (load) value = rand_val();
      if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
      if (en && $urandom_range(199) == 0) en = 1'b0;
      else if (!en && $urandom_range(2) == 0) en = 1'b1;
      step(1);
    end
    load = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
